// File: rtl/eth_mem_arbiter.sv
// eth_mem_arbiter: shares one APB master between RX and TX DMA with round-robin, burst lock and timeout abort
module eth_mem_arbiter #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_BURST = 16
) (
    input  logic        pclk_i,
    input  logic        prst_i,
    input  logic        rx_req_i,
    input  logic        tx_req_i,
    input  logic        rx_write_i,
    input  logic        tx_write_i,
    input  logic [31:0] rx_addr_i,
    input  logic [31:0] tx_addr_i,
    input  logic [31:0] rx_wdata_i,
    input  logic [31:0] tx_wdata_i,
    input  logic        rx_lock_i,
    input  logic        tx_lock_i,
    output logic        rx_done_o,
    output logic        tx_done_o,
    output logic        rx_err_o,
    output logic        tx_err_o,
    output logic [31:0] rdata_o,
    output logic        m_psel_o,
    output logic        m_penable_o,
    output logic        m_pwrite_o,
    output logic [31:0] m_paddr_o,
    output logic [31:0] m_pwdata_o,
    input  logic [31:0] m_prdata_i,
    input  logic        m_pready_i
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t        r_state, w_next;
    logic          r_owner, r_last_owner, r_lock, r_err, r_pwrite;
    logic [BW-1:0] r_burst_cnt;
    logic [TW-1:0] r_tcnt;
    logic [31:0]   r_paddr, r_pwdata, r_rdata;
    logic          w_any, w_lock_hit, w_grant, w_timeout, w_finish;

    // Owner selection (owner 0 = RX, 1 = TX) and next-state decode
    always_comb begin
        w_any      = rx_req_i | tx_req_i;
        w_lock_hit = r_lock && (r_burst_cnt < BW'(MAX_BURST)) && (r_last_owner ? tx_req_i : rx_req_i);
        w_grant    = w_lock_hit ? r_last_owner : (rx_req_i && tx_req_i) ? ~r_last_owner : tx_req_i;
        w_timeout  = r_tcnt == TW'(TIMEOUT - 1);
        w_finish   = m_pready_i || w_timeout;
        w_next     = r_state;
        case (r_state)
            S_IDLE:   w_next = w_any ? S_SETUP : S_IDLE;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: w_next = w_finish ? S_DONE : S_ACCESS;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge pclk_i) begin
        if (prst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Grant latching, wait counting, completion capture and lock sampling
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_lock       <= 1'b0;
            r_err        <= 1'b0;
            r_burst_cnt  <= '0;
            r_tcnt       <= '0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rdata      <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_owner     <= w_grant;
                r_burst_cnt <= w_lock_hit ? r_burst_cnt + BW'(1) : BW'(1);
                r_tcnt      <= '0;
                r_pwrite    <= w_grant ? tx_write_i : rx_write_i;
                r_paddr     <= w_grant ? tx_addr_i  : rx_addr_i;
                r_pwdata    <= w_grant ? tx_wdata_i : rx_wdata_i;
            end
            if (r_state == S_ACCESS && !w_finish) r_tcnt <= r_tcnt + TW'(1);
            if (r_state == S_ACCESS && w_finish) begin
                r_err   <= ~m_pready_i;
                r_rdata <= (m_pready_i && !r_pwrite) ? m_prdata_i : '0;
            end
            if (r_state == S_DONE) begin
                r_last_owner <= r_owner;
                r_lock       <= r_owner ? tx_lock_i : rx_lock_i;
            end
        end
    end

    assign m_psel_o    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign m_penable_o = r_state == S_ACCESS;
    assign m_pwrite_o  = r_pwrite;
    assign m_paddr_o   = r_paddr;
    assign m_pwdata_o  = r_pwdata;
    assign rdata_o     = r_rdata;
    assign rx_done_o   = (r_state == S_DONE) && !r_owner;
    assign tx_done_o   = (r_state == S_DONE) && r_owner;
    assign rx_err_o    = rx_done_o && r_err;
    assign tx_err_o    = tx_done_o && r_err;
endmodule

// File: tb/tb_eth_mem_arbiter.sv
// tb_eth_mem_arbiter: directed scoreboard bench for the RX/TX APB arbiter
module tb_eth_mem_arbiter;
    logic        pclk_i = 1'b0;
    logic        prst_i;
    logic        rx_req_i, tx_req_i, rx_write_i, tx_write_i, rx_lock_i, tx_lock_i;
    logic [31:0] rx_addr_i, tx_addr_i, rx_wdata_i, tx_wdata_i;
    logic        rx_done_o, tx_done_o, rx_err_o, tx_err_o;
    logic [31:0] rdata_o;
    logic        m_psel_o, m_penable_o, m_pwrite_o;
    logic [31:0] m_paddr_o, m_pwdata_o;
    logic [31:0] m_prdata_i = '0;
    logic        m_pready_i = 1'b0;

    eth_mem_arbiter #(.TIMEOUT(64), .MAX_BURST(16)) dut (
        .pclk_i(pclk_i), .prst_i(prst_i),
        .rx_req_i(rx_req_i), .tx_req_i(tx_req_i),
        .rx_write_i(rx_write_i), .tx_write_i(tx_write_i),
        .rx_addr_i(rx_addr_i), .tx_addr_i(tx_addr_i),
        .rx_wdata_i(rx_wdata_i), .tx_wdata_i(tx_wdata_i),
        .rx_lock_i(rx_lock_i), .tx_lock_i(tx_lock_i),
        .rx_done_o(rx_done_o), .tx_done_o(tx_done_o),
        .rx_err_o(rx_err_o), .tx_err_o(tx_err_o),
        .rdata_o(rdata_o),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o),
        .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } setup_t;

    typedef struct packed {
        logic        owner;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } done_t;

    setup_t      setup_q[$];
    done_t       done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ws = 0;
    logic        never_ready = 1'b0;
    logic [31:0] slave_data = '0;

    always @(posedge pclk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_xfer(input logic own, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic er, input int c);
        setup_q.push_back('{addr: a, write: wr, wdata: wd});
        done_q.push_back('{owner: own, err: er, rdata: (wr || er) ? 32'h0 : slave_data, cyc: 32'(c)});
    endtask

    task automatic set_rx(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        rx_write_i = wr; rx_addr_i = a; rx_wdata_i = wd; rx_req_i = 1'b1;
    endtask

    task automatic set_tx(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        tx_write_i = wr; tx_addr_i = a; tx_wdata_i = wd; tx_req_i = 1'b1;
    endtask

    // Keeps requests up until each requester has seen its quota of done pulses
    task automatic run_until(input int rx_n, input int tx_n);
        int rl = rx_n;
        int tl = tx_n;
        int t = 0;
        logic rd, td;
        while ((rl > 0 || tl > 0) && t < 2000) begin
            @(negedge pclk_i);
            rd = rx_done_o;
            td = tx_done_o;
            @(posedge pclk_i);
            #1;
            if (rd && rl > 0) begin
                rl--;
                if (rl == 0) rx_req_i = 1'b0;
            end
            if (td && tl > 0) begin
                tl--;
                if (tl == 0) tx_req_i = 1'b0;
            end
            t++;
        end
        chk("run_timeout", 32'(t >= 2000), 32'h0);
    endtask

    // APB slave: ready after ws ACCESS cycles unless told never to answer
    initial begin
        int acc = 0;
        forever begin
            @(negedge pclk_i);
            if (m_psel_o && m_penable_o) begin
                m_pready_i = !never_ready && (acc == ws);
                m_prdata_i = slave_data;
                acc++;
            end else begin
                m_pready_i = 1'b0;
                acc = 0;
            end
        end
    end

    // Monitor: pops expectations on every SETUP phase and every done pulse
    initial begin
        setup_t s;
        done_t  d;
        logic   prev_done = 1'b0;
        forever begin
            @(negedge pclk_i);
            if (!prst_i) begin
                if (m_psel_o && !m_penable_o) begin
                    if (setup_q.size() == 0) chk("unexpected_setup", m_paddr_o, 32'hFFFF_FFFF);
                    else begin
                        s = setup_q.pop_front();
                        chk("setup_addr", m_paddr_o, s.addr);
                        chk("setup_write", 32'(m_pwrite_o), 32'(s.write));
                        chk("setup_wdata", m_pwdata_o, s.wdata);
                    end
                end
                if (rx_done_o || tx_done_o) begin
                    chk("done_exclusive", 32'(rx_done_o & tx_done_o), 32'h0);
                    chk("done_back_to_back", 32'(prev_done), 32'h0);
                    if (done_q.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
                    else begin
                        d = done_q.pop_front();
                        chk("done_owner", 32'(tx_done_o), 32'(d.owner));
                        chk("done_err", 32'(d.owner ? tx_err_o : rx_err_o), 32'(d.err));
                        chk("done_rdata", rdata_o, d.rdata);
                        chk("done_cycle", 32'(cyc), d.cyc);
                    end
                end
            end
            prev_done = rx_done_o | tx_done_o;
        end
    end

    initial begin
        int n;
        prst_i = 1'b1;
        {rx_req_i, tx_req_i, rx_write_i, tx_write_i, rx_lock_i, tx_lock_i} = '0;
        {rx_addr_i, tx_addr_i, rx_wdata_i, tx_wdata_i} = '0;
        repeat (3) @(posedge pclk_i);
        @(negedge pclk_i);
        chk("rst_done_err", {28'h0, rx_done_o, tx_done_o, rx_err_o, tx_err_o}, 32'h0);
        chk("rst_ctrl", {29'h0, m_psel_o, m_penable_o, m_pwrite_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_paddr", m_paddr_o, 32'h0);
        chk("rst_pwdata", m_pwdata_o, 32'h0);
        @(posedge pclk_i); #1 prst_i = 1'b0;
        // Tie right after reset: RX then TX, 4 cycles apart
        @(posedge pclk_i); #1 n = cyc;
        slave_data = 32'h1111_2222; ws = 0;
        set_rx(1'b0, 32'h200, 32'hAAAA_0001);
        set_tx(1'b1, 32'h300, 32'h0000_0055);
        expect_xfer(1'b0, 1'b0, 32'h200, 32'hAAAA_0001, 1'b0, n + 3);
        expect_xfer(1'b1, 1'b1, 32'h300, 32'h0000_0055, 1'b0, n + 7);
        run_until(1, 1);
        // Continuous contention without lock alternates RX/TX
        n = cyc; slave_data = 32'h1357_2468;
        set_rx(1'b0, 32'h400, 32'h0000_0401);
        set_tx(1'b0, 32'h500, 32'h0000_0501);
        for (int k = 0; k < 6; k++)
            if (k % 2 == 0) expect_xfer(1'b0, 1'b0, 32'h400, 32'h0000_0401, 1'b0, n + 3 + 4 * k);
            else            expect_xfer(1'b1, 1'b0, 32'h500, 32'h0000_0501, 1'b0, n + 3 + 4 * k);
        run_until(3, 3);
        // TX lock: RX first (TX was last), then 16 locked TX, then RX, then TX
        n = cyc; slave_data = 32'h5A5A_C3C3; tx_lock_i = 1'b1;
        set_rx(1'b0, 32'h1000, 32'h0000_1001);
        set_tx(1'b1, 32'h2000, 32'hBEEF_0001);
        for (int k = 0; k < 19; k++)
            if (k == 0 || k == 17) expect_xfer(1'b0, 1'b0, 32'h1000, 32'h0000_1001, 1'b0, n + 3 + 4 * k);
            else                   expect_xfer(1'b1, 1'b1, 32'h2000, 32'hBEEF_0001, 1'b0, n + 3 + 4 * k);
        run_until(2, 17);
        tx_lock_i = 1'b0;
        // RX read alone, zero wait states
        n = cyc; slave_data = 32'hCAFE_F00D; ws = 0;
        set_rx(1'b0, 32'h100, 32'h0);
        expect_xfer(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, n + 3);
        run_until(1, 0);
        // Slave never ready: abort with err and rdata cleared
        n = cyc; never_ready = 1'b1; slave_data = 32'hDEAD_DEAD;
        set_tx(1'b0, 32'h600, 32'h0000_0601);
        expect_xfer(1'b1, 1'b0, 32'h600, 32'h0000_0601, 1'b1, n + 66);
        run_until(0, 1);
        never_ready = 1'b0;
        // Write with three wait states
        n = cyc; ws = 3;
        set_tx(1'b1, 32'h700, 32'h1234_5678);
        expect_xfer(1'b1, 1'b1, 32'h700, 32'h1234_5678, 1'b0, n + 6);
        run_until(0, 1);
        // Ready on the last allowed ACCESS cycle still succeeds
        n = cyc; ws = 63; slave_data = 32'h0BAD_BEEF;
        set_rx(1'b0, 32'h800, 32'h0000_0801);
        expect_xfer(1'b0, 1'b0, 32'h800, 32'h0000_0801, 1'b0, n + 66);
        run_until(1, 0);
        // Reset during ACCESS: bus drops next cycle, no done
        ws = 3;
        setup_q.push_back('{addr: 32'h900, write: 1'b0, wdata: 32'h0000_0901});
        set_tx(1'b0, 32'h900, 32'h0000_0901);
        n = 0;
        while (!(m_psel_o && m_penable_o) && n < 20) begin
            @(negedge pclk_i);
            n++;
        end
        chk("reach_access", 32'(n < 20), 32'h1);
        prst_i = 1'b1; tx_req_i = 1'b0;
        @(negedge pclk_i);
        chk("rst_mid_bus", {30'h0, m_psel_o, m_penable_o}, 32'h0);
        chk("rst_mid_done", {30'h0, rx_done_o, tx_done_o}, 32'h0);
        chk("rst_mid_rdata", rdata_o, 32'h0);
        @(posedge pclk_i); #1 prst_i = 1'b0;
        // After reset RX wins the tie again
        @(posedge pclk_i); #1 n = cyc;
        ws = 0; slave_data = 32'h7777_0000;
        set_rx(1'b0, 32'hA00, 32'h0000_0A01);
        set_tx(1'b0, 32'hB00, 32'h0000_0B01);
        expect_xfer(1'b0, 1'b0, 32'hA00, 32'h0000_0A01, 1'b0, n + 3);
        expect_xfer(1'b1, 1'b0, 32'hB00, 32'h0000_0B01, 1'b0, n + 7);
        run_until(1, 1);
        repeat (3) @(posedge pclk_i);
        chk("done_q_drained", 32'(done_q.size()), 32'h0);
        chk("setup_q_drained", 32'(setup_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
